// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-type codes, FSM states
// and the legality checks applied to every request.
package dmem_pkg;

    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_W  = 3'b010;
    localparam logic [2:0] BHW_BU = 3'b100;
    localparam logic [2:0] BHW_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_illegal(input logic [2:0] bhw);
        logic bad;
        case (bhw)
            BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU: bad = 1'b0;
            default:                             bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Only meaningful for legal codes; illegal codes are caught by is_illegal.
    function automatic logic is_misaligned(input logic [2:0] bhw, input logic [1:0] lane);
        logic mis;
        case (bhw)
            BHW_H, BHW_HU: mis = lane[0];
            BHW_W:         mis = |lane;
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory functional unit (master) and the
// data-memory responder (slave).
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_bhw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_bhw, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_bhw, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering: builds byte enables and the replicated write word for stores,
// and picks/extends the addressed byte or halfword for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  bhw_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    assign selByte = rdword_i[{lane_i, 3'b000} +: 8];
    assign selHalf = lane_i[1] ? rdword_i[31:16] : rdword_i[15:0];

    // bhw[2] marks the unsigned load variants; stores treat BU/HU as B/H.
    always_comb begin
        be_o    = 4'b0000;
        wword_o = 32'h0;
        rdata_o = 32'h0;
        case (bhw_i)
            BHW_B, BHW_BU: begin
                be_o    = 4'b0001 << lane_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{selByte[7] & ~bhw_i[2]}}, selByte};
            end
            BHW_H, BHW_HU: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{selHalf[15] & ~bhw_i[2]}}, selHalf};
            end
            BHW_W: begin
                be_o    = 4'b1111;
                wword_o = wdata_i;
                rdata_o = rdword_i;
            end
            default: begin
                be_o    = 4'b0000;
                wword_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers with a
// single-cycle response a fixed LATENCY cycles later, backed by a word array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        bhw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem [DEPTH];

    logic              acceptReq;
    logic              enterResp;
    logic              accErr;
    logic [ADDR_W-3:0] wordIdx;
    logic [3:0]        byteEn;
    logic [31:0]       wrWord;
    logic [31:0]       ldData;
    logic              unused_addr_hi;

    assign acceptReq      = (state_q == IDLE) && bus.req_valid;
    assign wordIdx        = addr_q[ADDR_W-1:2];
    assign accErr         = is_illegal(bhw_q) || is_misaligned(bhw_q, addr_q[1:0]);
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    dmem_lane_align u_align (
        .bhw_i    (bhw_q),
        .lane_i   (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdword_i (mem[wordIdx]),
        .be_o     (byteEn),
        .wword_o  (wrWord),
        .rdata_o  (ldData)
    );

    // Every request passes through BUSY, even at LATENCY=1, so the response
    // always lands exactly LATENCY edges after acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enterResp = 1'b0;
        case (state_q)
            IDLE: begin
                if (acceptReq) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    enterResp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enterResp) begin
            err_d   = accErr;
            rdata_d = (accErr || we_q) ? 32'h0 : ldData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acceptReq) begin
            we_q    <= bus.req_we;
            bhw_q   <= bus.req_bhw;
            addr_q  <= bus.req_addr[ADDR_W-1:0];
            wdata_q <= bus.req_wdata;
        end
    end

    // Storage survives reset; a reset landing on the RESP edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && we_q && !accErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/latency sequences and a
// randomized run against a byte-addressed reference memory.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  bhw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    logic        clk;
    logic        rst;
    int          sel;
    int          curLat;
    logic        drvValid;
    logic        drvWe;
    logic [2:0]  drvBhw;
    logic [31:0] drvAddr;
    logic [31:0] drvWdata;
    logic        obsReady;
    logic        obsValid;
    logic [31:0] obsRdata;
    logic        obsErr;
    int          total;
    int          bad;
    vec_t        vecs[$];
    logic [7:0]  modelMem [3][4096];

    dmem_if bus2();
    dmem_if bus1();
    dmem_if bus15();

    dmem_responder #(.ADDR_W(12), .LATENCY(2))  dutLat2  (.clk(clk), .rst(rst), .bus(bus2));
    dmem_responder #(.ADDR_W(12), .LATENCY(1))  dutLat1  (.clk(clk), .rst(rst), .bus(bus1));
    dmem_responder #(.ADDR_W(12), .LATENCY(15)) dutLat15 (.clk(clk), .rst(rst), .bus(bus15));

    assign bus2.req_valid  = drvValid && (sel == 0);
    assign bus1.req_valid  = drvValid && (sel == 1);
    assign bus15.req_valid = drvValid && (sel == 2);
    assign bus2.req_we     = drvWe;
    assign bus1.req_we     = drvWe;
    assign bus15.req_we    = drvWe;
    assign bus2.req_bhw    = drvBhw;
    assign bus1.req_bhw    = drvBhw;
    assign bus15.req_bhw   = drvBhw;
    assign bus2.req_addr   = drvAddr;
    assign bus1.req_addr   = drvAddr;
    assign bus15.req_addr  = drvAddr;
    assign bus2.req_wdata  = drvWdata;
    assign bus1.req_wdata  = drvWdata;
    assign bus15.req_wdata = drvWdata;

    assign obsReady = (sel == 0) ? bus2.req_ready  : (sel == 1) ? bus1.req_ready  : bus15.req_ready;
    assign obsValid = (sel == 0) ? bus2.resp_valid : (sel == 1) ? bus1.resp_valid : bus15.resp_valid;
    assign obsRdata = (sel == 0) ? bus2.resp_rdata : (sel == 1) ? bus1.resp_rdata : bus15.resp_rdata;
    assign obsErr   = (sel == 0) ? bus2.resp_err   : (sel == 1) ? bus1.resp_err   : bus15.resp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // Reference memory as a flat byte array: sizes, alignment and extension come
    // straight from the access rules, with no notion of lanes or states.
    task automatic modelAccess(input int s, input logic we, input logic [2:0] bhw,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] expRdata, output logic expErr);
        int          size;
        int          base;
        logic [31:0] val;
        size     = (bhw[1:0] == 2'd0) ? 1 : (bhw[1:0] == 2'd1) ? 2 : 4;
        base     = int'(addr[11:0]);
        expErr   = !(bhw inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || ((base % size) != 0);
        expRdata = 32'h0;
        if (!expErr) begin
            if (we) begin
                for (int k = 0; k < size; k++) modelMem[s][base + k] = wdata[8*k +: 8];
            end else begin
                val = 32'h0;
                for (int k = 0; k < size; k++) val[8*k +: 8] = modelMem[s][base + k];
                if (!bhw[2] && size < 4 && val[8*size - 1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
                expRdata = val;
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] gotRdata, output logic gotErr);
        int   waitCyc;
        int   lat;
        int   lowCnt;
        logic seen;
        gotRdata = 32'h0;
        gotErr   = 1'b0;
        @(negedge clk);
        waitCyc = 0;
        while (!obsReady && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!obsReady) begin
            total++;
            bad++;
            $display("[TB] FAIL ready-timeout: req_ready=0 required=1");
            return;
        end
        drvWe    = we;
        drvBhw   = bhw;
        drvAddr  = addr;
        drvWdata = wdata;
        drvValid = 1'b1;
        @(posedge clk);
        #1;
        drvValid = 1'b0;
        drvWe    = 1'($urandom_range(0, 1));
        drvBhw   = 3'($urandom());
        drvAddr  = $urandom();
        drvWdata = $urandom();
        lowCnt   = obsReady ? 0 : 1;
        lat      = 0;
        seen     = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!obsReady) lowCnt++;
            if (obsValid) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL resp-timeout: resp_valid=0 after %0d edges required=1", lat);
            return;
        end
        checkOutput("latency", 32'(lat), 32'(curLat));
        gotRdata = obsRdata;
        gotErr   = obsErr;
        @(posedge clk);
        #1;
        checkOutput("pulse-width", 32'(obsValid), 32'd0);
        checkOutput("ready-low-cycles", 32'(lowCnt), 32'(curLat + 1));
        checkOutput("rdata-hold", obsRdata, gotRdata);
    endtask

    task automatic addVec(input logic we, input logic [2:0] bhw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] expRdata, input logic expErr);
        vec_t v;
        v.we       = we;
        v.bhw      = bhw;
        v.addr     = addr;
        v.wdata    = wdata;
        v.expRdata = expRdata;
        v.expErr   = expErr;
        vecs.push_back(v);
    endtask

    // Runs one access, checking the DUT against the reference memory.
    task automatic modelTxn(input string tag, input logic we, input logic [2:0] bhw,
                            input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] mR;
        logic        mE;
        logic [31:0] gR;
        logic        gE;
        modelAccess(sel, we, bhw, addr, wdata, mR, mE);
        applyStimulus(we, bhw, addr, wdata, gR, gE);
        checkOutput({tag, " rdata"}, gR, mR);
        checkOutput({tag, " err"}, 32'(gE), 32'(mE));
    endtask

    initial begin
        logic [31:0] gR;
        logic        gE;
        logic [31:0] mR;
        logic        mE;
        logic        sawValid;
        logic [2:0]  codes [8];
        int          waitCyc;

        total    = 0;
        bad      = 0;
        sel      = 0;
        curLat   = 2;
        drvValid = 1'b0;
        drvWe    = 1'b0;
        drvBhw   = 3'b000;
        drvAddr  = 32'h0;
        drvWdata = 32'h0;
        codes    = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput($sformatf("reset%0d ready", s), 32'(obsReady), 32'd1);
            checkOutput($sformatf("reset%0d valid", s), 32'(obsValid), 32'd0);
            checkOutput($sformatf("reset%0d rdata", s), obsRdata, 32'h0);
            checkOutput($sformatf("reset%0d err", s), 32'(obsErr), 32'd0);
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;

        addVec(1'b1, BHW_W,  32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0);
        addVec(1'b0, BHW_W,  32'h010, 32'h0,        32'hDEADBEEF, 1'b0);
        addVec(1'b1, BHW_W,  32'h020, 32'h80FF7F01, 32'h00000000, 1'b0);
        addVec(1'b0, BHW_B,  32'h021, 32'h0,        32'h0000007F, 1'b0);
        addVec(1'b0, BHW_B,  32'h022, 32'h0,        32'hFFFFFFFF, 1'b0);
        addVec(1'b0, BHW_BU, 32'h023, 32'h0,        32'h00000080, 1'b0);
        addVec(1'b0, BHW_H,  32'h022, 32'h0,        32'hFFFF80FF, 1'b0);
        addVec(1'b0, BHW_HU, 32'h022, 32'h0,        32'h000080FF, 1'b0);
        addVec(1'b0, BHW_H,  32'h020, 32'h0,        32'h00007F01, 1'b0);
        addVec(1'b1, BHW_W,  32'h030, 32'h11223344, 32'h00000000, 1'b0);
        addVec(1'b1, BHW_B,  32'h031, 32'h123456AA, 32'h00000000, 1'b0);
        addVec(1'b1, BHW_H,  32'h032, 32'h9999BBCC, 32'h00000000, 1'b0);
        addVec(1'b0, BHW_W,  32'h030, 32'h0,        32'hBBCCAA44, 1'b0);
        addVec(1'b1, BHW_W,  32'h040, 32'hCAFEF00D, 32'h00000000, 1'b0);
        addVec(1'b1, BHW_H,  32'h041, 32'h00001234, 32'h00000000, 1'b1);
        addVec(1'b0, BHW_W,  32'h040, 32'h0,        32'hCAFEF00D, 1'b0);
        addVec(1'b0, BHW_W,  32'h042, 32'h0,        32'h00000000, 1'b1);
        addVec(1'b0, 3'b011, 32'h040, 32'h0,        32'h00000000, 1'b1);
        addVec(1'b0, BHW_W,  32'h040, 32'h0,        32'hCAFEF00D, 1'b0);
        addVec(1'b1, BHW_BU, 32'h043, 32'hFFFFFF77, 32'h00000000, 1'b0);
        addVec(1'b1, BHW_HU, 32'h040, 32'hABCD5566, 32'h00000000, 1'b0);
        addVec(1'b0, BHW_W,  32'h040, 32'h0,        32'h77FE5566, 1'b0);
        addVec(1'b1, 3'b110, 32'h040, 32'h0,        32'h00000000, 1'b1);
        addVec(1'b0, 3'b111, 32'h044, 32'h0,        32'h00000000, 1'b1);
        addVec(1'b0, BHW_W,  32'h040, 32'h0,        32'h77FE5566, 1'b0);
        addVec(1'b0, BHW_HU, 32'h042, 32'h0,        32'h000077FE, 1'b0);
        addVec(1'b0, BHW_H,  32'h043, 32'h0,        32'h00000000, 1'b1);
        addVec(1'b1, BHW_W,  32'h1004, 32'h5,       32'h00000000, 1'b0);
        addVec(1'b0, BHW_W,  32'h004, 32'h0,        32'h00000005, 1'b0);
        addVec(1'b0, BHW_B,  32'h1004, 32'h0,       32'h00000005, 1'b0);

        foreach (vecs[i]) begin
            modelAccess(0, vecs[i].we, vecs[i].bhw, vecs[i].addr, vecs[i].wdata, mR, mE);
            applyStimulus(vecs[i].we, vecs[i].bhw, vecs[i].addr, vecs[i].wdata, gR, gE);
            checkOutput($sformatf("vec%0d rdata", i), gR, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d err", i), 32'(gE), 32'(vecs[i].expErr));
        end

        // Reset while a store sits in BUSY: no response, and the word is untouched.
        modelTxn("pre-rst sw", 1'b1, BHW_W, 32'h050, 32'h11111111);
        modelTxn("pre-rst lw", 1'b0, BHW_W, 32'h050, 32'h0);
        @(negedge clk);
        waitCyc = 0;
        while (!obsReady && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        drvWe    = 1'b1;
        drvBhw   = BHW_W;
        drvAddr  = 32'h050;
        drvWdata = 32'h9;
        drvValid = 1'b1;
        @(posedge clk);
        #1;
        drvValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst valid", 32'(obsValid), 32'd0);
        checkOutput("midrst ready", 32'(obsReady), 32'd1);
        checkOutput("midrst rdata", obsRdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (obsValid) sawValid = 1'b1;
        end
        checkOutput("midrst no-resp", 32'(sawValid), 32'd0);
        modelTxn("post-rst lw", 1'b0, BHW_W, 32'h050, 32'h0);

        for (int w = 0; w < 32; w++) begin
            modelTxn($sformatf("init%0d", w), 1'b1, BHW_W, 32'(w * 4), $urandom());
        end
        for (int n = 0; n < 150; n++) begin
            modelTxn($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), codes[$urandom_range(0, 7)],
                     $urandom() & 32'hFFFFF07F, $urandom());
        end

        for (int s = 1; s <= 2; s++) begin
            sel    = s;
            curLat = (s == 1) ? 1 : 15;
            modelTxn($sformatf("lat%0d sw", curLat), 1'b1, BHW_W, 32'h008, $urandom());
            modelTxn($sformatf("lat%0d lw", curLat), 1'b0, BHW_W, 32'h008, 32'h0);
            modelTxn($sformatf("lat%0d lb", curLat), 1'b0, BHW_B, 32'h009, 32'h0);
            modelTxn($sformatf("lat%0d lw-mis", curLat), 1'b0, BHW_W, 32'h00A, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
